// File: rtl/iqmap_pkg.sv
// rtl/iqmap_pkg.sv - mode encodings, symbol sizes, Gray level tables and scaling constants for iqmap_multi
package iqmap_pkg;

  typedef enum logic [1:0] {
    MODE_QPSK  = 2'd0,
    MODE_16QAM = 2'd1,
    MODE_64QAM = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Signed constellation level, range -7..+7
  typedef logic signed [3:0] level_t;

  localparam int MAX_BPS = 6;

  // Normalisation constants 1/sqrt(2), 1/sqrt(10), 1/sqrt(42) in Q1.15
  localparam int NORM_FRAC = 15;
  localparam logic [15:0] NORM_QPSK_Q15  = 16'd23170;
  localparam logic [15:0] NORM_16QAM_Q15 = 16'd10362;
  localparam logic [15:0] NORM_64QAM_Q15 = 16'd5056;

  // Reserved mode falls back to QPSK sizing
  function automatic logic [2:0] bits_per_symbol(mode_e m);
    case (m)
      MODE_16QAM: return 3'd4;
      MODE_64QAM: return 3'd6;
      default:    return 3'd2;
    endcase
  endfunction

  function automatic level_t gray1(logic b);
    return b ? -4'sd1 : 4'sd1;
  endfunction

  function automatic level_t gray2(logic [1:0] b);
    case (b)
      2'b00:   return 4'sd3;
      2'b01:   return 4'sd1;
      2'b11:   return -4'sd1;
      default: return -4'sd3;
    endcase
  endfunction

  function automatic level_t gray3(logic [2:0] b);
    case (b)
      3'b000:  return 4'sd7;
      3'b001:  return 4'sd5;
      3'b011:  return 4'sd3;
      3'b010:  return 4'sd1;
      3'b110:  return -4'sd1;
      3'b111:  return -4'sd3;
      3'b101:  return -4'sd5;
      default: return -4'sd7;
    endcase
  endfunction

  // Left shift that turns a level into an IQ_W-bit sample; 7 << shift still fits
  function automatic int scale_shift(int iq_w);
    return iq_w - 4;
  endfunction

  function automatic logic [15:0] norm_q15(mode_e m);
    case (m)
      MODE_16QAM: return NORM_16QAM_Q15;
      MODE_64QAM: return NORM_64QAM_Q15;
      default:    return NORM_QPSK_Q15;
    endcase
  endfunction

endpackage

// File: rtl/iqmap_gray_lut.sv
// rtl/iqmap_gray_lut.sv - combinational (mode, head symbol bits) to Gray I/Q levels
module iqmap_gray_lut
  import iqmap_pkg::*;
(
  input  mode_e      mode,
  input  logic [5:0] sym,
  output level_t     i_lvl,
  output level_t     q_lvl
);

  // sym[5] is b0 (first transmitted); even bits feed I, odd bits feed Q
  always_comb begin
    i_lvl = '0;
    q_lvl = '0;
    case (mode)
      MODE_16QAM: begin
        i_lvl = gray2({sym[5], sym[3]});
        q_lvl = gray2({sym[4], sym[2]});
      end
      MODE_64QAM: begin
        i_lvl = gray3({sym[5], sym[3], sym[1]});
        q_lvl = gray3({sym[4], sym[2], sym[0]});
      end
      default: begin
        i_lvl = gray1(sym[5]);
        q_lvl = gray1(sym[4]);
      end
    endcase
  end

endmodule

// File: rtl/iqmap_multi.sv
// rtl/iqmap_multi.sv - word-to-symbol serialiser and QPSK/16QAM/64QAM Gray mapper; IQMAP_NORM_EN selects normalised levels
module iqmap_multi
  import iqmap_pkg::*;
#(
  parameter int WORD_W = 128,
  parameter int IQ_W   = 8,
  parameter int BUF_W  = WORD_W + 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WORD_W-1:0]      reader_data,
  input  logic                   valid_i,
  output logic                   ce,
  input  logic [1:0]             mode_i,
  input  logic                   flush_i,
  output logic signed [IQ_W-1:0] i_o,
  output logic signed [IQ_W-1:0] q_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy
);

  localparam int FILL_W = $clog2(BUF_W + 1);

  // Accumulator is MSB-aligned: the next symbol always sits at the top bits,
  // and every bit below the fill level is kept at zero so a new word can be ORed in.
  logic [BUF_W-1:0]  acc;
  logic [BUF_W-1:0]  acc_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [FILL_W-1:0] fill_rem;
  logic [FILL_W-1:0] bps_w;
  mode_e             mode_q;
  logic              pop;
  logic              accept;
  logic              can_take;
  level_t            i_lvl;
  level_t            q_lvl;

  assign bps_w    = FILL_W'(bits_per_symbol(mode_q));
  assign pop      = (fill >= bps_w) && can_take;
  assign fill_rem = pop ? (fill - bps_w) : fill;
  assign ce       = !flush_i && (fill_rem < bps_w);
  assign accept   = valid_i && ce;

  iqmap_gray_lut u_lut (
    .mode  (mode_q),
    .sym   (acc[BUF_W-1 -: MAX_BPS]),
    .i_lvl (i_lvl),
    .q_lvl (q_lvl)
  );

  // Next accumulator/fill: consume the head symbol, append the word below the residual, or flush
  always_comb begin
    acc_next  = pop ? (acc << bps_w) : acc;
    fill_next = fill_rem;
    if (accept) begin
      acc_next  = acc_next | ({reader_data, {(BUF_W - WORD_W){1'b0}}} >> fill_rem);
      fill_next = fill_rem + FILL_W'(WORD_W);
    end
    if (flush_i) begin
      acc_next  = '0;
      fill_next = '0;
    end
  end

  // Accumulator, fill count and mode latch; mode only changes when a word lands in an empty buffer
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc    <= '0;
      fill   <= '0;
      mode_q <= MODE_QPSK;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
      if (accept && (fill == '0)) begin
        mode_q <= mode_e'(mode_i);
      end
    end
  end

`ifdef IQMAP_NORM_EN
  // Normalised build: levels are registered once, scaled, then held in a
  // 2-entry skid whose head drives the outputs. Requires IQ_W <= 15.
  localparam int NORM_SH = NORM_FRAC - (IQ_W - 1);
  localparam int SAT_MAX = (1 << (IQ_W - 1)) - 1;

  logic                   s1_valid;
  level_t                 s1_i;
  level_t                 s1_q;
  mode_e                  s1_mode;
  logic signed [IQ_W-1:0] fifo_i [2];
  logic signed [IQ_W-1:0] fifo_q [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;
  logic                   out_take;
  logic signed [IQ_W-1:0] i_norm;
  logic signed [IQ_W-1:0] q_norm;

  // Round half away from zero on the magnitude, then saturate symmetrically
  function automatic logic signed [IQ_W-1:0] normalize(level_t lvl, mode_e m);
    int prod;
    int mag;
    int rnd;
    prod = int'(lvl) * int'(norm_q15(m));
    mag  = (prod < 0) ? -prod : prod;
    rnd  = (mag + (1 << (NORM_SH - 1))) >>> NORM_SH;
    if (rnd > SAT_MAX) rnd = SAT_MAX;
    return IQ_W'((prod < 0) ? -rnd : rnd);
  endfunction

  assign i_norm   = normalize(s1_i, s1_mode);
  assign q_norm   = normalize(s1_q, s1_mode);
  assign valid_o  = (count != 2'd0);
  assign i_o      = fifo_i[rd_ptr];
  assign q_o      = fifo_q[rd_ptr];
  assign out_take = valid_o && ready_i;
  // A pop is allowed only if the symbol in flight plus the new one still fit in the skid
  assign can_take = (int'(count) + int'(s1_valid) - int'(out_take)) < 2;
  assign busy     = (fill != '0) || s1_valid || valid_o;

  // Normalisation register and skid buffer
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      s1_mode   <= MODE_QPSK;
      fifo_i[0] <= '0;
      fifo_i[1] <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      s1_valid <= pop;
      if (pop) begin
        s1_i    <= i_lvl;
        s1_q    <= q_lvl;
        s1_mode <= mode_q;
      end
      if (s1_valid) begin
        fifo_i[wr_ptr] <= i_norm;
        fifo_q[wr_ptr] <= q_norm;
        wr_ptr         <= ~wr_ptr;
      end
      if (out_take) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, s1_valid} - {1'b0, out_take};
    end
  end
`else
  localparam int SHIFT = scale_shift(IQ_W);

  logic signed [IQ_W-1:0] i_scaled;
  logic signed [IQ_W-1:0] q_scaled;

  assign i_scaled = {{(IQ_W - 4){i_lvl[3]}}, i_lvl} << SHIFT;
  assign q_scaled = {{(IQ_W - 4){q_lvl[3]}}, q_lvl} << SHIFT;
  assign can_take = !valid_o || ready_i;
  assign busy     = (fill != '0) || valid_o;

  // Output register: load on pop, hold while stalled, drop valid when drained
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_o     <= '0;
      q_o     <= '0;
      valid_o <= 1'b0;
    end else if (pop) begin
      i_o     <= i_scaled;
      q_o     <= q_scaled;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_iqmap_multi.sv
// tb/tb_iqmap_multi.sv - scoreboard bench for iqmap_multi (default build)
module tb_iqmap_multi;

  localparam int WORD_W = 128;
  localparam int IQ_W   = 8;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [WORD_W-1:0]      reader_data;
  logic                   valid_i;
  logic                   ce;
  logic [1:0]             mode_i;
  logic                   flush_i;
  logic signed [IQ_W-1:0] i_o;
  logic signed [IQ_W-1:0] q_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp_e;
  bit          mbits [$];
  int          mmode = 0;
  int          lv2 [4] = '{3, 1, -3, -1};
  int          lv3 [8] = '{7, 5, 1, 3, -7, -5, -1, -3};

  always #5 CLK = ~CLK;

  iqmap_multi #(.WORD_W(WORD_W), .IQ_W(IQ_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .reader_data (reader_data),
    .valid_i     (valid_i),
    .ce          (ce),
    .mode_i      (mode_i),
    .flush_i     (flush_i),
    .i_o         (i_o),
    .q_o         (q_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy        (busy)
  );

  always @(negedge CLK) begin
    if (!RST && valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got i=%0d q=%0d, expected no sample", i_o, q_o);
      end else begin
        exp_e = exp_q.pop_front();
        if ({i_o, q_o} !== exp_e) begin
          errors++;
          $display("FAIL sb_sample %0d: got i=%0d q=%0d, expected i=%0d q=%0d",
                   n_out, i_o, q_o, $signed(exp_e[15:8]), $signed(exp_e[7:0]));
        end
      end
      n_out++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic model_accept(input logic [WORD_W-1:0] w);
    int bps;
    int il;
    int ql;
    bit b [6];
    if (mbits.size() == 0) mmode = (mode_i == 2'd3) ? 0 : int'(mode_i);
    for (int k = WORD_W - 1; k >= 0; k--) mbits.push_back(w[k]);
    bps = (mmode == 1) ? 4 : (mmode == 2) ? 6 : 2;
    while (mbits.size() >= bps) begin
      for (int k = 0; k < 6; k++) b[k] = 1'b0;
      for (int k = 0; k < bps; k++) b[k] = mbits.pop_front();
      case (mmode)
        1: begin
          il = lv2[{b[0], b[2]}];
          ql = lv2[{b[1], b[3]}];
        end
        2: begin
          il = lv3[{b[0], b[2], b[4]}];
          ql = lv3[{b[1], b[3], b[5]}];
        end
        default: begin
          il = b[0] ? -1 : 1;
          ql = b[1] ? -1 : 1;
        end
      endcase
      exp_q.push_back({8'(il * 16), 8'(ql * 16)});
    end
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    int t;
    bit ok;
    reader_data = w;
    valid_i = 1'b1;
    t = 0;
    ok = 1'b0;
    while (t < 400) begin
      @(negedge CLK);
      if (ce) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ce=%b, expected 1 within 400 cycles", ce);
    end else begin
      model_accept(w);
    end
    @(posedge CLK);
    #1 valid_i = 1'b0;
  endtask

  task automatic ce_gap(output int n);
    bit found;
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      n++;
      if (ce) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) n = -1;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge CLK);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d samples outstanding, expected 0", exp_q.size());
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_o); end
    checks++; if (i_o !== 8'sd0) begin errors++; $display("FAIL reset_i: got %0d, expected 0", i_o); end
    checks++; if (q_o !== 8'sd0) begin errors++; $display("FAIL reset_q: got %0d, expected 0", q_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL idle_ce: got %b, expected 1", ce); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_16qam();
    int base;
    mode_i = 2'd1;
    ready_i = 1'b1;
    base = n_out;
    send_word(128'hABCDEF0123456789FEDCBA9876543210);
    @(negedge CLK);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL qam16_latency1: valid_o=%b, expected 0", valid_o); end
    @(negedge CLK);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL qam16_latency2: valid_o=%b, expected 1", valid_o); end
    checks++; if (i_o !== -8'sd16 || q_o !== 8'sd48) begin
      errors++; $display("FAIL qam16_first: got i=%0d q=%0d, expected i=-16 q=48", i_o, q_o);
    end
    wait_drain(200);
    @(negedge CLK);
    checks++; if (n_out - base != 32) begin errors++; $display("FAIL qam16_count: got %0d, expected 32", n_out - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL qam16_busy: got %b, expected 0", busy); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_qpsk();
    int base;
    int n;
    mode_i = 2'd0;
    base = n_out;
    send_word(128'hA0F012345678_9ABCDEF013579BDF0246);
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (i_o !== -8'sd16 || q_o !== 8'sd16) begin
      errors++; $display("FAIL qpsk_first: got i=%0d q=%0d, expected i=-16 q=16", i_o, q_o);
    end
    @(posedge CLK);
    #1;
    ce_gap(n);
    checks++; if (n != 62) begin errors++; $display("FAIL qpsk_ce_rise: got cycle %0d, expected 62", n); end
    send_word(128'h0123456789ABCDEF_5A5A5A5AC3C3C3C3);
    wait_drain(300);
    @(negedge CLK);
    checks++; if (n_out - base != 128) begin errors++; $display("FAIL qpsk_count: got %0d, expected 128", n_out - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL qpsk_busy: got %b, expected 0", busy); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_64qam_residual();
    int base;
    int n;
    int gap_exp [3] = '{21, 21, 22};
    mode_i = 2'd2;
    base = n_out;
    for (int w = 0; w < 3; w++) begin
      send_word({WORD_W{1'b1}});
      ce_gap(n);
      checks++; if (n != gap_exp[w]) begin
        errors++; $display("FAIL qam64_ce_word%0d: got cycle %0d, expected %0d", w, n, gap_exp[w]);
      end
    end
    wait_drain(200);
    @(negedge CLK);
    checks++; if (n_out - base != 64) begin errors++; $display("FAIL qam64_count: got %0d, expected 64", n_out - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL qam64_busy: got %b, expected 0", busy); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_backpressure();
    int base;
    logic signed [IQ_W-1:0] hi;
    logic signed [IQ_W-1:0] hq;
    logic hv;
    mode_i = 2'd1;
    ready_i = 1'b1;
    base = n_out;
    send_word({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 200 && n_out - base < 5; k++) @(posedge CLK);
    #1 ready_i = 1'b0;
    @(negedge CLK);
    hi = i_o;
    hq = q_o;
    hv = valid_o;
    checks++; if (hv !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, expected 1", hv); end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++; if (i_o !== hi || q_o !== hq || valid_o !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got i=%0d q=%0d v=%b, expected i=%0d q=%0d v=1", k, i_o, q_o, valid_o, hi, hq);
      end
    end
    @(posedge CLK);
    #1 ready_i = 1'b1;
    wait_drain(200);
    @(negedge CLK);
    checks++; if (n_out - base != 32) begin errors++; $display("FAIL bp_count: got %0d, expected 32", n_out - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b, expected 0", busy); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_mode_flush();
    int base;
    mode_i = 2'd1;
    ready_i = 1'b1;
    base = n_out;
    send_word(128'h3C96E1A50F7B2D48_C3691E5AF084D2B7);
    for (int k = 0; k < 200 && n_out - base < 2; k++) @(posedge CLK);
    #1 ready_i = 1'b0;
    mode_i = 2'd2;
    repeat (3) @(posedge CLK);
    #1 ready_i = 1'b1;
    repeat (4) @(posedge CLK);
    #1 ready_i = 1'b0;
    repeat (2) @(posedge CLK);
    #1 flush_i = 1'b1;
    @(negedge CLK);
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL flush_ce: got %b, expected 0", ce); end
    @(posedge CLK);
    #1 flush_i = 1'b0;
    mbits.delete();
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(negedge CLK);
    checks++; if (valid_o !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_hold: got valid_o=%b busy=%b, expected 1 1", valid_o, busy);
    end
    @(posedge CLK);
    #1 ready_i = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b, expected 0", busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_left: %0d outstanding, expected 0", exp_q.size()); end
    @(posedge CLK);
    #1;
    base = n_out;
    send_word(128'hFEDCBA9876543210_0123456789ABCDEF);
    wait_drain(200);
    @(negedge CLK);
    checks++; if (n_out - base != 21) begin errors++; $display("FAIL newmode_count: got %0d, expected 21", n_out - base); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL residual_busy: got %b, expected 1", busy); end
    @(posedge CLK);
    #1 flush_i = 1'b1;
    @(posedge CLK);
    #1 flush_i = 1'b0;
    mbits.delete();
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL residual_flush: got %b, expected 0", busy); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid();
    int base;
    mode_i = 2'd2;
    ready_i = 1'b1;
    base = n_out;
    send_word(128'h5A3C_9E71_0F2D_B486_77E1_3C5A_D2B4_0819);
    for (int k = 0; k < 200 && n_out - base < 3; k++) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
    mbits.delete();
    @(negedge CLK);
    checks++; if (valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got valid_o=%b busy=%b, expected 0 0", valid_o, busy);
    end
    checks++; if (i_o !== 8'sd0 || q_o !== 8'sd0) begin
      errors++; $display("FAIL midreset_iq: got i=%0d q=%0d, expected 0 0", i_o, q_o);
    end
    @(posedge CLK);
    #1;
    base = n_out;
    send_word(128'hF1E2D3C4B5A69788_7968574635241302);
    wait_drain(200);
    @(negedge CLK);
    checks++; if (n_out - base != 21) begin errors++; $display("FAIL midreset_count: got %0d, expected 21", n_out - base); end
    @(posedge CLK);
    #1 flush_i = 1'b1;
    @(posedge CLK);
    #1 flush_i = 1'b0;
    mbits.delete();
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    mode_i = 2'd0;
    reader_data = '0;
    test_reset();
    test_16qam();
    test_qpsk();
    test_64qam_residual();
    test_backpressure();
    test_mode_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iqmap_multi.md
Name: iqmap_multi

Overview:
- Parametrised successor to the fixed 16QAM IQ mapper.
- Accepts wide bit words (reader_data) from the frame reader and serialises them MSB-first into symbols.
- Maps each symbol to Gray-coded I/Q for QPSK, 16QAM or 64QAM, selectable per run.
- Carries leftover bits across word boundaries (needed because 128 is not a multiple of 6), and supports output backpressure toward the IFFT/carrier-mapping stage.

Parameters:
- WORD_W, 128: input word width in bits; must be ≥ 6.
- IQ_W, 8: signed output width of each I and Q sample; must be ≥ 5.
- BUF_W, WORD_W+5: bit accumulator width (maximum residual 5 bits plus one word).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- reader_data  in  WORD_W  input bit word; bit WORD_W-1 is transmitted first.
- valid_i  in  1  reader_data is valid.
- ce  out  1  word accept strobe; combinational; the word transfers in a cycle where valid_i && ce.
- mode_i  in  2  0 = QPSK, 1 = 16QAM, 2 = 64QAM, 3 = reserved (treated as QPSK).
- flush_i  in  1  discard residual bits in the accumulator.
- i_o  out  IQ_W  signed in-phase sample.
- q_o  out  IQ_W  signed quadrature sample.
- valid_o  out  1  i_o/q_o are valid.
- ready_i  in  1  downstream accepts the sample.
- busy  out  1  accumulator not empty, or valid_o is high.

Behaviour:
- Reset:
  - RST=1 at a rising edge clears fill count, accumulator, i_o, q_o and valid_o to 0, and sets the latched mode to QPSK.
  - Reset overrides every other input, including in mid-word or mid-stall cases.
- Bits per symbol (BPS) = 2/4/6 for QPSK/16QAM/64QAM. Symbol bits b0..b(BPS-1) are taken in order from the accumulator head.
- Bit split: even bits (b0, b2, b4) form the I index; odd bits (b1, b3, b5) form the Q index.
- Gray levels:
  - 1 bit: 0→+1, 1→-1.
  - 2 bits: 00→+3, 01→+1, 11→-1, 10→-3.
  - 3 bits: 000→+7, 001→+5, 011→+3, 010→+1, 110→-1, 111→-3, 101→-5, 100→-7.
- Output value = level × 2^(IQ_W-4), sign-extended to IQ_W bits.
- Pop:
  - Allowed when fill ≥ BPS and (!valid_o || ready_i).
  - On a pop, the symbol is registered into i_o/q_o and valid_o=1 on the next edge.
  - Latency from a word accepted into an empty buffer to valid_o is 2 cycles.
- Hold: while valid_o && !ready_i, i_o, q_o and valid_o are held and nothing pops.
- When ready_i is high and no pop is possible, valid_o clears.
- ce = !flush_i && (fill - (pop ? BPS : 0)) < BPS.
- Accept: the accepted word is appended below the residual bits, and fill += WORD_W.
- Accept and pop may occur in the same cycle; the new fill = fill - BPS + WORD_W.
- Mode latch: mode_i is latched only on an accept while fill==0. Changes while fill≠0 are ignored until the buffer drains or is flushed.
- flush_i:
  - Sets fill=0 on the next edge and blocks ce in that cycle.
  - A pop in the same cycle still completes.
  - valid_o and the registered sample are unaffected.
- A residual smaller than BPS with no further input stays in the accumulator; busy=1 until it is flushed.
- valid_i is ignored whenever ce=0; no overflow is possible by construction.

Optional Feature:
- Macro: IQMAP_NORM_EN.
- Defined:
  - Levels are multiplied by a per-mode normalisation constant: 1/√2, 1/√10 or 1/√42 in Q1.(IQ_W-1), rounded half away from zero and saturated.
  - This adds one pipeline register, so latency becomes 3 cycles.
  - The hold/backpressure rules apply at the final stage through a 2-entry skid.
- Undefined: unnormalised power-of-two scaling as above.

Decomposition:
- Package iqmap_pkg:
  - mode encodings and the BPS lookup;
  - Gray level tables;
  - IQ_W-derived scale shift;
  - normalisation constants.
- Natural sub-module: iqmap_gray_lut. It is purely combinational, taking (mode, symbol bits) → (I level, Q level), and is instantiated once.

Test Plan:
- 16QAM, reader_data=128'habcdef…, ready_i=1 → first symbol nibble A gives i_o=-16, q_o=+48; 32 symbols are produced, then busy=0.
- QPSK, word MSBs 2'b10 → i_o=-16, q_o=+16; 64 symbols per word; ce rises when fill drops below 2 with a pop pending.
- 64QAM, three words of all-ones → every symbol has i_o=q_o=-48; exactly 64 symbols, with residuals of 2 then 4 then 0 bits after each word; ce does not assert early.
- Backpressure: ready_i held 0 for 5 cycles mid-stream → i_o, q_o and valid_o are stable; no symbol is lost or duplicated (compare against a golden sequence).
- mode_i toggled mid-word, then flush_i=1 → mode is unchanged until the flush; after the flush, fill=0, the next accepted word uses the new mode, and busy falls.
- RST asserted mid-64QAM word → the next edge gives valid_o=0 and busy=0; the following word maps from its own bit 127, with no stale residual.
